// File: rtl/gpu_fb_scanout.sv
// Framebuffer scanout: fetches packed 2bpp words from RAM and streams pixels with line/frame markers.
// Start sampled at edge T gives a read strobe seen by edge T+1, a capture at T+2 and a first pixel seen by T+3; pixel and markers hold while iPixelReady is low.
module gpu_fb_scanout #(
    parameter int          WORDS_PER_LINE = 20,
    parameter int          LINES          = 144,
    parameter logic [15:0] BASE_ADDR      = 16'h0000
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic        iStartFrame,
    output logic        oFbReadEnable,
    output logic [15:0] oFbReadAddr,
    input  logic [15:0] iFbReadData,
    output logic [1:0]  oPixel,
    output logic        oPixelValid,
    input  logic        iPixelReady,
    output logic        oLineStart,
    output logic        oFrameStart,
    output logic        oFrameLast,
    output logic        oFrameDone,
    output logic        oBusy
);
    localparam int PIX_PER_LINE = WORDS_PER_LINE * 8;
    localparam int TOTAL_WORDS  = WORDS_PER_LINE * LINES;
    localparam int XW           = $clog2(PIX_PER_LINE);
    localparam int YW           = $clog2(LINES);
    localparam int WW           = $clog2(TOTAL_WORDS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state;
    logic [WW-1:0] words_issued;
    logic          rd_pending;

    logic [15:0]   fifo_mem [2];
    logic          fifo_wr_ptr;
    logic          fifo_rd_ptr;
    logic [1:0]    fifo_count;

    logic [15:0]   sh_word;
    logic [2:0]    sh_idx;
    logic          sh_valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic        start;
    logic        abort;
    logic        running;
    logic        xfer;
    logic        frame_last;
    logic        fifo_empty;
    logic        sh_load;
    logic        fifo_push;
    logic        fifo_pop;
    logic [1:0]  occ;
    logic [15:0] sh_src;

    assign start      = (state == S_IDLE) && iStartFrame && iEnable;
    assign abort      = (state != S_IDLE) && !iEnable;
    assign running    = (state == S_ACTIVE) && iEnable;
    assign xfer       = sh_valid && iPixelReady;
    assign frame_last = sh_valid && (x == XW'(PIX_PER_LINE - 1)) && (y == YW'(LINES - 1));
    assign fifo_empty = (fifo_count == 2'd0);
    assign occ        = fifo_count + {1'b0, rd_pending};

    assign oFbReadEnable = running && (occ < 2'd2) && (words_issued < WW'(TOTAL_WORDS));

    // Returning read data bypasses the FIFO when it is empty and the shifter wants a word,
    // so the first pixel appears right after the capture edge and reloads never bubble.
    assign sh_load   = running && (!sh_valid || (xfer && sh_idx == 3'd7)) && (!fifo_empty || rd_pending);
    assign sh_src    = fifo_empty ? iFbReadData : fifo_mem[fifo_rd_ptr];
    assign fifo_push = rd_pending && !(sh_load && fifo_empty);
    assign fifo_pop  = sh_load && !fifo_empty;

    assign oPixel      = sh_word[15:14];
    assign oPixelValid = sh_valid;
    assign oLineStart  = sh_valid && (x == '0);
    assign oFrameStart = sh_valid && (x == '0) && (y == '0);
    assign oFrameLast  = frame_last;
    assign oFrameDone  = (state == S_DONE) && iEnable;
    assign oBusy       = (state != S_IDLE);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_ACTIVE;
                S_ACTIVE: begin
                    if (abort)                   state <= S_IDLE;
                    else if (xfer && frame_last) state <= S_DONE;
                end
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oFbReadAddr  <= BASE_ADDR;
            words_issued <= '0;
            rd_pending   <= 1'b0;
        end else begin
            rd_pending <= oFbReadEnable;
            if (start) begin
                oFbReadAddr  <= BASE_ADDR;
                words_issued <= '0;
            end else if (oFbReadEnable) begin
                oFbReadAddr  <= oFbReadAddr + 16'd1;
                words_issued <= words_issued + WW'(1);
            end
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else if (abort || start) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= !fifo_wr_ptr;
            if (fifo_pop)  fifo_rd_ptr <= !fifo_rd_ptr;
            fifo_count <= fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge iClock) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr] <= iFbReadData;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            sh_word  <= '0;
            sh_idx   <= '0;
            sh_valid <= 1'b0;
        end else if (abort || start) begin
            sh_word  <= '0;
            sh_idx   <= '0;
            sh_valid <= 1'b0;
        end else if (sh_load) begin
            sh_word  <= sh_src;
            sh_idx   <= '0;
            sh_valid <= 1'b1;
        end else if (xfer) begin
            sh_word <= {sh_word[13:0], 2'b00};
            sh_idx  <= sh_idx + 3'd1;
            if (sh_idx == 3'd7) sh_valid <= 1'b0;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            x <= '0;
            y <= '0;
        end else if (abort || start) begin
            x <= '0;
            y <= '0;
        end else if (xfer) begin
            if (x == XW'(PIX_PER_LINE - 1)) begin
                x <= '0;
                y <= (y == YW'(LINES - 1)) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end
endmodule

// File: doc/gpu_fb_scanout.md
Name: gpu_fb_scanout

Overview:
Reader end of the GPU background framebuffer. The GPU writes 16-bit words, each holding 8 palette-converted 2-bit pixels. This block fetches those words sequentially from the framebuffer RAM read port and serialises them into a ready/valid pixel stream, with line and frame markers, for the LCD driver. It sits between the framebuffer RAM and the display interface. It issues no writes.

Parameters:
WORDS_PER_LINE, 20, framebuffer words per scanline (160 px / 8).
LINES, 144, scanlines per frame.
BASE_ADDR, 16'h0000, framebuffer address of word 0 of line 0.

Ports:
iClock  input  1  system clock
iReset  input  1  reset
iEnable  input  1  block enable; low aborts any frame in progress
iStartFrame  input  1  single-cycle pulse that starts a frame scan
oFbReadEnable  output  1  read strobe to framebuffer RAM
oFbReadAddr  output  16  framebuffer read address
iFbReadData  input  16  read data, valid exactly 1 cycle after the strobe; {P7..P0}, P7 in bits [15:14]
oPixel  output  2  pixel value
oPixelValid  output  1  oPixel is valid
iPixelReady  input  1  display accepts the pixel
oLineStart  output  1  qualifies the current pixel as x==0
oFrameStart  output  1  qualifies the current pixel as x==0, y==0
oFrameLast  output  1  qualifies the current pixel as x==159, y==LINES-1
oFrameDone  output  1  one-cycle pulse after the last pixel transfers
oBusy  output  1  high in every state except IDLE

Behaviour:
- Interface: one clock, iClock. iReset is asynchronous and active-high.
- Reset: all outputs 0; oFbReadAddr = BASE_ADDR; state = IDLE; FIFO empty; x = y = 0.
- States:
  - IDLE: goes to ACTIVE when iStartFrame & iEnable. The read pointer, x and y are cleared on this transition.
  - ACTIVE: goes to DONE when the pixel flagged oFrameLast transfers.
  - DONE: held for exactly 1 cycle with oFrameDone=1, then returns to IDLE.
- iStartFrame is ignored outside IDLE.
- Abort: iEnable low in ACTIVE or DONE forces IDLE on the next edge.
  - FIFO, in-flight read, shift register and oPixelValid are cleared.
  - oFrameDone is not pulsed.
- Read issue:
  - In ACTIVE, oFbReadEnable=1 when (FIFO count + in-flight) < 2 and words issued < WORDS_PER_LINE*LINES.
  - oFbReadAddr = BASE_ADDR + word index, 16-bit wrap.
  - Addresses increment by 1 per issued read.
- Capture: data is written into a 2-entry word FIFO in the cycle after the strobe. The FIFO can never overflow by construction.
- Shifter:
  - Holds the current word and a 3-bit pixel index.
  - Loads from the FIFO when empty, or when the current pixel 7 transfers (zero-bubble reload if the FIFO is non-empty).
- Pixel output order per word: bits [15:14], [13:12], ..., [1:0].
- Handshake:
  - A transfer occurs when oPixelValid & iPixelReady.
  - While oPixelValid & ~iPixelReady, oPixel and all markers hold stable.
  - oPixelValid never drops without a transfer, except on abort or reset.
- Counters: x runs 0..159 and wraps to 0 on transfer, incrementing y. y runs 0..LINES-1.
- Latency: for an iStartFrame sampled at edge T:
  - oFbReadEnable is high in cycle T+1;
  - the data is captured at T+2;
  - oPixelValid is first high in cycle T+3.
- Throughput: with iPixelReady held high, 1 pixel per cycle, no bubbles, from the first pixel to the last.
- Total per frame: WORDS_PER_LINE*LINES reads and WORDS_PER_LINE*8*LINES pixels.

Test Plan:
- Full frame: defaults, iPixelReady=1, RAM word k = k.
  - 2880 reads at addresses 0..2879 in order.
  - 23040 pixels.
  - oFrameStart once; oLineStart 144 times; oFrameLast once.
  - oFrameDone 1 cycle after the last transfer; first valid at T+3.
- Pixel order: word 0 = 16'hE41B -> first 8 pixels 3,2,1,0,0,1,2,3, with oLineStart and oFrameStart on the first.
- Backpressure: random iPixelReady at 30% duty.
  - Pixel sequence is identical to the full-frame run.
  - oPixel is stable while stalled.
  - (FIFO count + in-flight) never exceeds 2.
- Abort: drop iEnable after pixel 1000.
  - Next cycle: IDLE, oPixelValid=0, oBusy=0, no oFrameDone.
  - A new iStartFrame restarts at address BASE_ADDR with x=y=0.
- Async reset mid-frame: assert iReset between clock edges.
  - All outputs go to 0 immediately.
  - After release, a pulse on iStartFrame scans a full, correct frame.
- iStartFrame pulsed in ACTIVE and in DONE -> ignored; exactly one frame is produced.
